// File: rtl/fir_tap_reader.sv
// fir_tap_reader
//   Read-side address sequencer for the FIR sample buffer. A start latches the
//   newest-sample address. The block then walks the circular sample buffer
//   backwards (newest first) while it walks the coefficient ROM forwards. It
//   issues one (sample_addr, coef_addr) pair per accepted cycle over a
//   valid/ready handshake, and pulses done once the last pair is taken.
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous reset, active low
//     start        one-cycle request for one output sample (IDLE only)
//     wr_addr      newest-sample address from the write side
//     rd_ready     MAC accepts the current pair this cycle
//     rd_valid     sample_addr/coef_addr hold a valid pair
//     sample_addr  sample buffer read address
//     coef_addr    coefficient ROM read address
//     first        pair is tap 0 (MAC clears its accumulator)
//     last         pair is tap TAPS-1
//     busy         high in RUN and DONE
//     done         one-cycle pulse after the last pair is accepted
module fir_tap_reader #(
  parameter int ADDR_W = 5,
  parameter int TAPS   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] sample_addr,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              first,
  output logic              last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One bit wider than the address so the tap index compare cannot overflow
  // even when TAPS == 2^ADDR_W.
  localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W+1)'(TAPS - 1);
  localparam logic [ADDR_W:0]   ONE_W    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] sample_q, sample_d;
  logic [ADDR_W-1:0] coef_q, coef_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   coef_nxt;

  assign coef_nxt = {1'b0, coef_q} + ONE_W;

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    sample_d = sample_q;
    coef_d   = coef_q;
    first_d  = first_q;
    last_d   = last_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        first_d = 1'b0;
        last_d  = 1'b0;
        if (start) begin
          // Base address goes straight into the sample pointer; later
          // wr_addr changes are not looked at until the next accepted start.
          state_d  = RUN;
          valid_d  = 1'b1;
          sample_d = wr_addr;
          coef_d   = '0;
          first_d  = 1'b1;
          last_d   = (TAPS == 1);
        end
      end
      RUN: begin
        // Without rd_ready everything holds: the stall is free to last forever.
        if (valid_q && rd_ready) begin
          if (last_q) begin
            state_d = DONE;
            valid_d = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // Decrement wraps naturally at 2^ADDR_W (circular buffer).
            sample_d = sample_q - ONE;
            coef_d   = coef_nxt[ADDR_W-1:0];
            first_d  = 1'b0;
            last_d   = (coef_nxt == LAST_IDX);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        first_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // busy is registered from the next state so it lines up with rd_valid/done.
  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      sample_q <= '0;
      coef_q   <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      sample_q <= sample_d;
      coef_q   <= coef_d;
      first_q  <= first_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign rd_valid    = valid_q;
  assign sample_addr = sample_q;
  assign coef_addr   = coef_q;
  assign first       = first_q;
  assign last        = last_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
